// File: rtl/q_6_pkg.sv
// Shared constants and FSM state encoding for the q_6_21 down counter.
package q_6_pkg;

  localparam int WIDTH  = 8;
  localparam int NIBBLE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/four_bit_sync_down_cntr.sv
// One nibble of the down counter: a loadable counter that wraps 0 -> F when enabled.
// The borrow output lets the next nibble up count on that wrap.
module four_bit_sync_down_cntr
  import q_6_pkg::*;
(
  input  logic              rstn,
  input  logic              clk,
  input  logic              cnt_en,
  input  logic              load,
  input  logic [NIBBLE-1:0] I,
  output logic [NIBBLE-1:0] count,
  output logic              borrow
);

  localparam logic [NIBBLE-1:0] ONE = {{(NIBBLE-1){1'b0}}, 1'b1};

  logic [NIBBLE-1:0] count_d, count_q;

  // NOTE: default assignment first so every path drives count_d -- no latch.
  always_comb begin
    count_d = count_q;
    if (load)        count_d = I;
    else if (cnt_en) count_d = count_q - ONE;
  end

  // NOTE: non-blocking for all flop updates so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count  = count_q;
  assign borrow = cnt_en & (count_q == '0);

endmodule

// File: rtl/q_6_21.sv
// Loadable 8-bit down counter with optional auto-reload and a two-state busy FSM.
// Built from two nibble counters chained through the lower nibble's borrow.
module q_6_21
  import q_6_pkg::*;
#(
  parameter int WIDTH = q_6_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cnt_en,
  input  logic             load,
  input  logic [WIDTH-1:0] I,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             borrow,
  output logic             zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] reload_d, reload_q;
  state_e           state_d, state_q;

  logic             lo_borrow, hi_borrow;
  logic             term_cnt;
  logic             sub_load;
  logic [WIDTH-1:0] sub_i;

  // At terminal count both nibbles are loaded instead of wrapping to all-ones:
  // with the reload value, or with zero so the counter parks at 0.
  assign term_cnt = hi_borrow & ~load;
  assign sub_load = load | term_cnt;
  assign sub_i    = load ? I : (auto_reload ? reload_q : '0);

  four_bit_sync_down_cntr u_lo (
    .rstn   (rstb),
    .clk    (clk),
    .cnt_en (cnt_en),
    .load   (sub_load),
    .I      (sub_i[NIBBLE-1:0]),
    .count  (count[NIBBLE-1:0]),
    .borrow (lo_borrow)
  );

  four_bit_sync_down_cntr u_hi (
    .rstn   (rstb),
    .clk    (clk),
    .cnt_en (lo_borrow),
    .load   (sub_load),
    .I      (sub_i[2*NIBBLE-1:NIBBLE]),
    .count  (count[2*NIBBLE-1:NIBBLE]),
    .borrow (hi_borrow)
  );

  always_comb begin
    reload_d = reload_q;
    state_d  = state_q;
    if (load) begin
      reload_d = I;
      state_d  = (I != '0) ? RUN : IDLE;
    end else if (cnt_en && state_q == RUN) begin
      // Leave RUN whenever this edge leaves the counter parked at zero.
      if (!auto_reload && (count == ONE || count == '0))
        state_d = IDLE;
      else if (auto_reload && count == '0 && reload_q == '0)
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      reload_q <= '0;
      state_q  <= IDLE;
    end else begin
      reload_q <= reload_d;
      state_q  <= state_d;
    end
  end

  assign borrow = term_cnt;
  assign zero   = (count == '0);
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_q_6_21.sv
// Self-checking bench for q_6_21: a per-cycle reference model plus directed
// scenarios with hand-computed expected values.
module tb_q_6_21;

  logic       clk = 1'b0;
  logic       rstb;
  logic       cnt_en;
  logic       load;
  logic [7:0] ld_val;
  logic       auto_reload;
  logic [7:0] count;
  logic       borrow;
  logic       zero;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  q_6_21 dut (
    .clk         (clk),
    .rstb        (rstb),
    .cnt_en      (cnt_en),
    .load        (load),
    .I           (ld_val),
    .auto_reload (auto_reload),
    .count       (count),
    .borrow      (borrow),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: the counter value, the remembered reload value and whether
  // the counter is considered busy, updated from the input rules directly.
  int m_cnt, m_rel;
  bit m_busy;

  always @(posedge clk or negedge rstb) begin
    int nc;
    bit nb;
    if (!rstb) begin
      m_cnt  <= 0;
      m_rel  <= 0;
      m_busy <= 1'b0;
    end else if (load) begin
      m_cnt  <= int'(ld_val);
      m_rel  <= int'(ld_val);
      m_busy <= (ld_val != 8'h00);
    end else if (cnt_en) begin
      nc = m_cnt;
      nb = m_busy;
      if (m_cnt != 0)       nc = m_cnt - 1;
      else if (auto_reload) nc = m_rel;
      if (nc == 0 && (!auto_reload || m_cnt == 0)) nb = 1'b0;
      m_cnt  <= nc;
      m_busy <= nb;
    end
  end

  always @(negedge clk) begin
    check("model_count",  32'(count),  32'(m_cnt));
    check("model_zero",   32'(zero),   32'(m_cnt == 0));
    check("model_busy",   32'(busy),   32'(m_busy));
    check("model_borrow", 32'(borrow), 32'(cnt_en && !load && m_cnt == 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp37[6];
  int exp39[9];
  int borrow_seen;

  initial begin
    exp37 = '{4, 3, 2, 1, 0, 0};
    exp39 = '{2, 1, 0, 3, 2, 1, 0, 3, 2};

    rstb = 1'b0; cnt_en = 1'b0; load = 1'b0; ld_val = 8'h00; auto_reload = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'h0);
    check("rst_zero",  32'(zero),  32'h1);
    check("rst_busy",  32'(busy),  32'h0);
    cnt_en = 1'b1;
    #1;
    check("rst_borrow_follows_en", 32'(borrow), 32'h1);
    cnt_en = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
    tick();

    // Count down from 5 with no reload, then hold at zero.
    load = 1'b1; ld_val = 8'h05; cnt_en = 1'b1;
    tick();
    load = 1'b0;
    check("ld5_count", 32'(count), 32'h05);
    check("ld5_busy",  32'(busy),  32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("dn5_count", 32'(count), 32'(exp37[i]));
      check("dn5_busy",  32'(busy),  32'(exp37[i] != 0));
      check("dn5_borrow", 32'(borrow), 32'(exp37[i] == 0));
    end

    // Lower-nibble wrap carries into the upper nibble on the same edge.
    load = 1'b1; ld_val = 8'h10;
    tick();
    load = 1'b0;
    check("ld10_count", 32'(count), 32'h10);
    check("ld10_borrow", 32'(borrow), 32'h0);
    tick();
    check("nib_carry_count", 32'(count), 32'h0F);
    check("nib_carry_borrow", 32'(borrow), 32'h0);

    // Auto-reload from 3: one borrow per period, busy throughout.
    auto_reload = 1'b1; load = 1'b1; ld_val = 8'h03;
    tick();
    load = 1'b0;
    check("ar_ld_count", 32'(count), 32'h03);
    borrow_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("ar_count", 32'(count), 32'(exp39[i]));
      check("ar_busy",  32'(busy),  32'h1);
      if (borrow) borrow_seen++;
    end
    check("ar_borrow_pulses", 32'(borrow_seen), 32'd2);

    // Disabling reload mid-count affects only the next terminal count.
    auto_reload = 1'b0;
    tick();
    check("ar_off_count1", 32'(count), 32'h01);
    tick();
    check("ar_off_count0", 32'(count), 32'h00);
    check("ar_off_busy",   32'(busy),  32'h0);

    // Load wins over the terminal count on the same cycle.
    load = 1'b1; ld_val = 8'h80;
    #1;
    check("ld_at_zero_borrow", 32'(borrow), 32'h0);
    tick();
    load = 1'b0;
    check("ld80_count", 32'(count), 32'h80);
    check("ld80_busy",  32'(busy),  32'h1);

    // Asynchronous reset mid-count at 0x42.
    load = 1'b1; ld_val = 8'h45;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_count", 32'(count), 32'h42);
    #2;
    rstb = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'h0);
    check("async_rst_busy",  32'(busy),  32'h0);
    check("async_rst_zero",  32'(zero),  32'h1);
    auto_reload = 1'b1;
    tick();
    #2;
    rstb = 1'b1;
    tick();
    check("post_rst_count", 32'(count), 32'h0);
    check("post_rst_busy",  32'(busy),  32'h0);
    tick();
    check("post_rst_hold", 32'(count), 32'h0);

    // Loading zero while running forces IDLE.
    load = 1'b1; ld_val = 8'h20;
    tick();
    check("ld20_busy", 32'(busy), 32'h1);
    ld_val = 8'h00;
    tick();
    load = 1'b0;
    check("ld0_count", 32'(count), 32'h0);
    check("ld0_busy",  32'(busy),  32'h0);
    check("ld0_zero",  32'(zero),  32'h1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/q_6_21.md
Q_6_21 -- requirements
Module: q_6_21

Interface
REQ-001 The block SHALL have a single clock, clk, with the parameter WIDTH, default 8, meaning counter width in bits.
REQ-002 clk  input  1  rising-edge clock; all state changes occur on its rising edge.
REQ-003 rstb  input  1  asynchronous, active-low reset.
REQ-004 cnt_en  input  1  decrement enable.
REQ-005 load  input  1  synchronous parallel-load strobe.
REQ-006 I  input  8  parallel-load value; also captured as the reload value.
REQ-007 auto_reload  input  1  1 = reload on terminal count; 0 = stop at zero.
REQ-008 count  output  8  current counter value.
REQ-009 borrow  output  1  terminal-count indication, combinational.
REQ-010 zero  output  1  count == 0, combinational.
REQ-011 busy  output  1  FSM in RUN.

Function
REQ-012 Load SHALL have priority over cnt_en: load=1 SHALL set count<=I and reload_reg<=I at the next edge, regardless of cnt_en.
REQ-013 load=0, cnt_en=1, count!=0 SHALL decrement count by exactly 1 per edge.
REQ-014 load=0, cnt_en=1, count==0, auto_reload=1 SHALL set count<=reload_reg.
REQ-015 load=0, cnt_en=1, count==0, auto_reload=0 SHALL hold count at 0; no wrap to 8'hFF.
REQ-016 cnt_en=0 and load=0 SHALL hold count.
REQ-017 borrow SHALL equal cnt_en & ~load & (count==0), with no register delay.
REQ-018 The FSM SHALL have two states, IDLE and RUN.
REQ-019 IDLE->RUN SHALL occur on load with I!=0.
REQ-020 RUN->IDLE SHALL occur when load=0, cnt_en=1, count==1, auto_reload=0, i.e. the edge on which count reaches 0.
REQ-021 RUN with auto_reload=1 SHALL stay in RUN across reloads.
REQ-022 If reload_reg==0 while auto_reload=1 at terminal count, the FSM SHALL go to IDLE.
REQ-023 load with I==0 SHALL force IDLE at the next edge.
REQ-024 busy SHALL be 1 exactly when the state is RUN.
REQ-025 The upper nibble SHALL decrement only on an edge where the lower nibble is enabled and equals 0; the upper-nibble enable SHALL be the lower-nibble borrow.
REQ-026 Toggling auto_reload mid-count SHALL affect only the next terminal-count event.

Reset
REQ-027 rstb=0 SHALL immediately force count=0, reload_reg=0 and state=IDLE, independent of clk.
REQ-028 During reset the outputs SHALL be: zero=1, busy=0, and borrow=cnt_en.
REQ-029 Reset asserted mid-count SHALL discard the count and the reload value.
REQ-030 Reset deassertion SHALL NOT cause a count change on that same edge.

Structure
REQ-031 WIDTH=8, NIBBLE=4 and the FSM state encoding (IDLE=1'b0, RUN=1'b1) SHALL live in a shared package, q_6_pkg.
REQ-032 The counter SHALL be built from two instances of the sub-module four_bit_sync_down_cntr.
REQ-033 four_bit_sync_down_cntr ports SHALL be: rstn, clk, cnt_en, load, I[3:0], count[3:0], borrow.
REQ-034 In four_bit_sync_down_cntr, borrow SHALL equal cnt_en & (count==0).
REQ-035 The FSM and reload_reg SHALL reside in q_6_21.
REQ-036 There SHALL be no latches and no combinational loops.

Verification
REQ-037 Reset, load I=8'h05, cnt_en=1, auto_reload=0 -> count 5,4,3,2,1,0,0; busy falls on the edge count reaches 0; borrow=1 from the first cycle at 0 onward.
REQ-038 Load I=8'h10, cnt_en=1 -> count goes 10->0F with the upper nibble decrementing on the same edge; borrow=0.
REQ-039 Load I=8'h03, auto_reload=1, cnt_en=1 for 10 cycles -> count 3,2,1,0,3,2,1,0,3,2; busy stays 1; borrow pulses once per period.
REQ-040 count=0 with load=1, I=8'h80, cnt_en=1 on the same cycle -> borrow=0; count=8'h80 at the next edge; busy=1.
REQ-041 Assert rstb=0 asynchronously mid-cycle at count=8'h42 -> count=0, busy=0, zero=1 before the next clk edge; after release with cnt_en=1, auto_reload=1, count holds at 0 and busy=0.
REQ-042 Load I=8'h00 while in RUN -> IDLE and count=0 at the next edge; zero=1.
